// File: rtl/tdm_demux_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux_rx
//  Purpose  : TDM link receiver. Deserializes N_CH slots of WIDTH bits (MSB
//             first) framed by a one-cycle fsync strobe, and presents each
//             complete frame as parallel channel words with a valid pulse.
//             Tracks frame alignment and flags sync violations.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux_rx #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    I,
    input  logic                    fsync,
    output logic [N_CH*WIDTH-1:0]   Y,
    output logic                    valid,
    output logic                    locked,
    output logic                    sync_err
);

    localparam int c_BIT_W  = $clog2(WIDTH);
    localparam int c_SLOT_W = $clog2(N_CH);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WIDTH - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(N_CH - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);

    localparam logic [0:0] c_ST_HUNT    = 1'b0;
    localparam logic [0:0] c_ST_RECEIVE = 1'b1;

    logic [0:0]                 r_state;
    logic [c_BIT_W-1:0]         r_bit_cnt;
    logic [c_SLOT_W-1:0]        r_slot_cnt;
    logic [WIDTH-2:0]           r_shift;
    // Set for exactly the cycle where bit 0 of slot 0 of the next frame is due
    logic                       r_at_boundary;
    logic [N_CH*WIDTH-1:0]      r_y;
    logic                       r_valid;
    logic                       r_locked;
    logic                       r_sync_err;

    logic [WIDTH-1:0]           w_word;
    logic [(N_CH-1)*WIDTH-1:0]  w_shadow;
    logic                       w_receiving;
    logic                       w_lost;
    logic                       w_resync;
    logic                       w_slot_done;

    // Current slot word as it would be with this cycle's bit appended
    assign w_word      = {r_shift, I};
    assign w_receiving = (r_state == c_ST_RECEIVE);
    // Boundary reached without fsync: alignment lost
    assign w_lost      = w_receiving && r_at_boundary && !fsync;
    // fsync anywhere but the boundary: restart the frame on this bit
    assign w_resync    = w_receiving && !r_at_boundary && fsync;
    assign w_slot_done = w_receiving && !w_lost && !w_resync
                         && (r_bit_cnt == c_BIT_LAST);

    // Shadow words for every slot except the last, which bypasses into Y
    genvar g;
    generate
        for (g = 0; g < N_CH - 1; g++) begin : g_shadow
            logic [WIDTH-1:0] r_word;

            // Capture the finished slot word when this slot index completes
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_slot_done && (r_slot_cnt == c_SLOT_W'(g))) begin
                    r_word <= w_word;
                end
            end

            assign w_shadow[WIDTH*g +: WIDTH] = r_word;
        end
    endgenerate

    // Framing state machine, bit/slot counters, shift register and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_HUNT;
            r_bit_cnt     <= '0;
            r_slot_cnt    <= '0;
            r_shift       <= '0;
            r_at_boundary <= 1'b0;
            r_y           <= '0;
            r_valid       <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
            case (r_state)
                c_ST_HUNT: begin
                    if (fsync) begin
                        r_state       <= c_ST_RECEIVE;
                        r_locked      <= 1'b1;
                        r_shift       <= w_word[WIDTH-2:0];
                        r_bit_cnt     <= c_BIT_ONE;
                        r_slot_cnt    <= '0;
                        r_at_boundary <= 1'b0;
                    end
                end
                c_ST_RECEIVE: begin
                    if (w_lost) begin
                        // Bit is discarded; Y keeps the last delivered frame
                        r_sync_err    <= 1'b1;
                        r_state       <= c_ST_HUNT;
                        r_locked      <= 1'b0;
                        r_bit_cnt     <= '0;
                        r_slot_cnt    <= '0;
                        r_at_boundary <= 1'b0;
                    end else if (w_resync) begin
                        // Partial frame dropped; this bit is the new slot-0 MSB
                        r_sync_err    <= 1'b1;
                        r_shift       <= w_word[WIDTH-2:0];
                        r_bit_cnt     <= c_BIT_ONE;
                        r_slot_cnt    <= '0;
                        r_at_boundary <= 1'b0;
                    end else begin
                        r_shift       <= w_word[WIDTH-2:0];
                        r_at_boundary <= 1'b0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_bit_cnt <= '0;
                            if (r_slot_cnt == c_SLOT_LAST) begin
                                r_slot_cnt    <= '0;
                                r_y           <= {w_word, w_shadow};
                                r_valid       <= 1'b1;
                                r_at_boundary <= 1'b1;
                            end else begin
                                r_slot_cnt <= r_slot_cnt + c_SLOT_ONE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_HUNT;
                end
            endcase
        end
    end

    assign Y        = r_y;
    assign valid    = r_valid;
    assign locked   = r_locked;
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux_rx
//  Purpose  : Directed self-checking bench for tdm_demux_rx (WIDTH=8, N_CH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux_rx;

    localparam int WIDTH = 8;
    localparam int N_CH  = 4;
    localparam int F     = WIDTH * N_CH;

    logic              clk;
    logic              rst;
    logic              I;
    logic              fsync;
    logic [F-1:0]      Y;
    logic              valid;
    logic              locked;
    logic              sync_err;

    int checks;
    int errors;

    tdm_demux_rx #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .I        (I),
        .fsync    (fsync),
        .Y        (Y),
        .valid    (valid),
        .locked   (locked),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit on the falling edge, return 1 time unit after it is sampled
    task automatic send_bit(input logic b, input logic fs);
        @(negedge clk);
        I     = b;
        fsync = fs;
        @(posedge clk);
        #1;
    endtask

    // Send nbits of a frame (slot 0 first, MSB first), fsync on bit 0 if asked.
    // Records what valid/sync_err did along the way.
    task automatic send_bits(input logic [F-1:0] data, input int nbits,
                             input logic with_fs,
                             output int v_early, output logic v_last,
                             output logic se_first, output int se_rest);
        int slot;
        int bpos;
        v_early  = 0;
        v_last   = 1'b0;
        se_first = 1'b0;
        se_rest  = 0;
        for (int k = 0; k < nbits; k++) begin
            slot = k / WIDTH;
            bpos = WIDTH - 1 - (k % WIDTH);
            send_bit(data[slot*WIDTH + bpos], with_fs && (k == 0));
            if (k == 0) se_first = sync_err;
            else        se_rest += int'(sync_err);
            if (k == F - 1) v_last = valid;
            else            v_early += int'(valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst   = 1'b1;
        I     = 1'b0;
        fsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({Y, valid, locked, sync_err} !== {{F{1'b0}}, 3'b000}) begin
            errors++;
            $display("FAIL reset_outputs: Y=%h valid=%b locked=%b sync_err=%b, want all 0",
                     Y, valid, locked, sync_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [F-1:0] want,
                               input logic want_se_first,
                               input int v_early, input logic v_last,
                               input logic se_first, input int se_rest);
        checks++;
        if (v_early !== 0 || v_last !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: early_pulses=%0d last=%b, want 0 and 1",
                     name, v_early, v_last);
        end
        checks++;
        if (Y !== want) begin
            errors++;
            $display("FAIL %s_Y: got %h want %h", name, Y, want);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL %s_locked: got %b want 1", name, locked);
        end
        checks++;
        if (se_first !== want_se_first || se_rest !== 0) begin
            errors++;
            $display("FAIL %s_sync_err: first=%b rest=%0d, want %b and 0",
                     name, se_first, se_rest, want_se_first);
        end
    endtask

    task automatic test_single_frame();
        int v_e; logic v_l; logic se_f; int se_r;
        send_bits(32'hF00F3CA5, F, 1'b1, v_e, v_l, se_f, se_r);
        check_frame("single", 32'hF00F3CA5, 1'b0, v_e, v_l, se_f, se_r);
    endtask

    task automatic test_back_to_back();
        int v_e; logic v_l; logic se_f; int se_r;
        logic [F-1:0] frames [3];
        frames[0] = 32'h01020304;
        frames[1] = 32'hDEADBEEF;
        frames[2] = 32'h00000000;
        for (int n = 0; n < 3; n++) begin
            send_bits(frames[n], F, 1'b1, v_e, v_l, se_f, se_r);
            check_frame($sformatf("b2b%0d", n), frames[n], 1'b0, v_e, v_l, se_f, se_r);
        end
    endtask

    task automatic test_missing_fsync();
        int v_e; logic v_l; logic se_f; int se_r;
        send_bits(32'h12345678, F, 1'b1, v_e, v_l, se_f, se_r);
        check_frame("pre_miss", 32'h12345678, 1'b0, v_e, v_l, se_f, se_r);
        // Same stream continues but without fsync at the boundary
        send_bits(32'hCAFEBABE, F, 1'b0, v_e, v_l, se_f, se_r);
        checks++;
        if (se_f !== 1'b1 || se_r !== 0) begin
            errors++;
            $display("FAIL miss_sync_err: first=%b rest=%0d, want 1 and 0", se_f, se_r);
        end
        checks++;
        if (v_e !== 0 || v_l !== 1'b0) begin
            errors++;
            $display("FAIL miss_no_valid: early=%0d last=%b, want 0 and 0", v_e, v_l);
        end
        checks++;
        if (locked !== 1'b0 || Y !== 32'h12345678) begin
            errors++;
            $display("FAIL miss_hold: locked=%b Y=%h, want 0 and 12345678", locked, Y);
        end
        send_bits(32'h55AA33CC, F, 1'b1, v_e, v_l, se_f, se_r);
        check_frame("relock", 32'h55AA33CC, 1'b0, v_e, v_l, se_f, se_r);
    endtask

    task automatic test_early_fsync();
        int v_e; logic v_l; logic se_f; int se_r;
        send_bits(32'h11111111, 13, 1'b1, v_e, v_l, se_f, se_r);
        checks++;
        if (v_e !== 0 || se_f !== 1'b0 || se_r !== 0) begin
            errors++;
            $display("FAIL early_partial: valid=%0d se_first=%b se_rest=%0d, want 0 0 0",
                     v_e, se_f, se_r);
        end
        // fsync lands on bit 13 of the frame above
        send_bits(32'h9ABCDEF0, F, 1'b1, v_e, v_l, se_f, se_r);
        check_frame("early", 32'h9ABCDEF0, 1'b1, v_e, v_l, se_f, se_r);
    endtask

    task automatic test_reset_mid_frame();
        int v_e; logic v_l; logic se_f; int se_r;
        int pulses;
        send_bits(32'h77777777, 20, 1'b1, v_e, v_l, se_f, se_r);
        // Reset together with fsync: reset must win
        @(negedge clk);
        rst   = 1'b1;
        fsync = 1'b1;
        I     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({Y, valid, locked, sync_err} !== {{F{1'b0}}, 3'b000}) begin
            errors++;
            $display("FAIL rst_fsync: Y=%h valid=%b locked=%b sync_err=%b, want all 0",
                     Y, valid, locked, sync_err);
        end
        @(negedge clk);
        fsync = 1'b0;
        I     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            send_bit(1'b1, 1'b0);
            pulses += int'(valid) + int'(locked) + int'(sync_err);
        end
        checks++;
        if (pulses !== 0 || Y !== '0) begin
            errors++;
            $display("FAIL rst_quiet: activity=%0d Y=%h, want 0 and 0", pulses, Y);
        end
        send_bits(32'h0BADF00D, F, 1'b1, v_e, v_l, se_f, se_r);
        check_frame("post_rst", 32'h0BADF00D, 1'b0, v_e, v_l, se_f, se_r);
    endtask

    task automatic test_hunt_noise();
        test_reset();
        for (int k = 0; k < 200; k++) begin
            send_bit(1'($urandom_range(1, 0)), 1'b0);
            checks++;
            if ({Y, valid, locked, sync_err} !== {{F{1'b0}}, 3'b000}) begin
                errors++;
                $display("FAIL hunt_noise cycle %0d: Y=%h valid=%b locked=%b sync_err=%b, want all 0",
                         k, Y, valid, locked, sync_err);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        I      = 1'b0;
        fsync  = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_missing_fsync();
        test_early_fsync();
        test_reset_mid_frame();
        test_hunt_noise();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_demux_rx.md
# tdm_demux_rx

Receive end of the team's serial time-division multiplexed (TDM) link. It takes one serial bit stream carrying N_CH channel slots per frame, plus a frame-sync strobe. It deserializes each slot, demultiplexes the slots into parallel per-channel words and presents a complete frame with a one-cycle valid pulse. It sits after the TDM mux/serializer in the multiplexer/demultiplexer datapath and feeds the per-channel consumers.

## Interface
- WIDTH, 8, bits per channel slot (≥2)
- N_CH, 4, channel slots per frame (≥2); frame length F = N_CH*WIDTH cycles

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- I  input  1  serial data bit, one bit per clk cycle, MSB of each slot first
- fsync  input  1  frame sync; high for exactly one cycle, coincident with the MSB of slot 0
- Y  output  N_CH*WIDTH  demultiplexed frame; Y[WIDTH*(c+1)-1 : WIDTH*c] = channel c
- valid  output  1  one-cycle pulse, Y holds a newly completed frame
- locked  output  1  high while the receiver is tracking frames (RECEIVE state)
- sync_err  output  1  one-cycle pulse on a frame-sync violation

## Operation
- Reset values: Y=0, valid=0, locked=0, sync_err=0, state=HUNT, bit_cnt=0, slot_cnt=0, shift/shadow registers=0.
- State HUNT:
  - I is ignored while fsync=0.
  - fsync=1 samples I as bit WIDTH-1 of slot 0, sets bit_cnt=1 and slot_cnt=0, and enters RECEIVE.
- State RECEIVE: each cycle shifts I into the slot shift register (MSB first) and increments bit_cnt.
- Slot completion: when bit_cnt reaches WIDTH-1, the word {shift, I} is written to shadow[slot_cnt], bit_cnt wraps to 0, and slot_cnt increments.
- Frame completion: on the last bit of slot N_CH-1:
  - Y loads all shadow words, with the final slot taken directly from {shift, I}.
  - valid pulses; slot_cnt wraps to 0.
  - State stays RECEIVE, expecting fsync on the next cycle.
- Expected frame boundary (bit 0 of slot 0):
  - fsync=1: normal; that bit is the new MSB of slot 0.
  - fsync=0: sync_err pulses, the state returns to HUNT and locked drops. The bit is discarded. The previously delivered Y is kept.
- Early fsync (fsync=1 at any position other than the expected boundary):
  - sync_err pulses and the partial frame is discarded; no valid pulse.
  - The current bit becomes the MSB of slot 0 (bit_cnt=1, slot_cnt=0) and the state stays RECEIVE (resync without HUNT).
- Y changes only on frame completion or reset and holds between valid pulses.
- Shadow slots from an aborted frame are never exposed: Y loads only on a full frame.
- Counter widths: bit_cnt is clog2(WIDTH) bits and slot_cnt is clog2(N_CH) bits. Both wrap explicitly at WIDTH-1 and N_CH-1, never by overflow.

## Timing
- Frame latency: Y and valid update on the rising edge that samples the last bit of the frame. They are visible in the following cycle, so valid is high for exactly 1 cycle.
- Minimum frame period is F cycles; back-to-back frames give a valid every F cycles with no gap cycles.
- locked rises on the edge that samples fsync in HUNT. It falls on the edge that detects a missing boundary fsync.
- sync_err is registered and pulses the cycle after the offending edge. It is never high together with valid.
- Simultaneous rst and fsync: rst wins; the block is in HUNT with all outputs 0 on the next cycle.
- Reset mid-frame: the partial frame is lost and no valid pulse follows.

## Test plan
- WIDTH=8, N_CH=4, fsync then slots 0xA5, 0x3C, 0x0F, 0xF0 MSB-first -> valid pulses once 32 cycles after fsync, Y=32'hF00F3CA5, locked=1, sync_err never pulses.
- Three back-to-back frames, each with fsync at its boundary (0x01020304, 0xDEADBEEF, 0x00000000) -> valid every 32 cycles, Y matches each frame in order, locked stays 1.
- Stream a valid frame, then omit fsync at the next boundary -> sync_err pulse, locked=0, no further valid, Y keeps its last value. The next fsync relocks and delivers the following frame correctly.
- fsync reasserted at bit 13 of a frame -> sync_err pulse, no valid for the aborted frame. A complete frame starting at that fsync gives valid 32 cycles later with the correct Y.
- Assert rst at bit 20 of a frame, release, then send a full frame -> all outputs 0 after reset, no valid for the interrupted frame, correct Y for the new frame.
- Random bits on I with fsync held 0 from reset for 200 cycles -> locked=0, valid=0, sync_err=0, Y=0 throughout.
